proc_sequencer: RTL and testbench
=================================

PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: instruction-memory address width.
REQ-002 SHALL have parameter WDOG_LIMIT, default 3: max EXEC cycles allowed without Done.
REQ-003 Clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Resetn  in  1  asynchronous, active-low reset.
REQ-005 Start  in  1  begin execution at StartAddr; in FAULT, clears the fault.
REQ-006 Halt  in  1  stop request; honoured at the next instruction boundary.
REQ-007 StartAddr  in  ADDR_W  first instruction address.
REQ-008 EndAddr  in  ADDR_W  stop when the next PC equals this value.
REQ-009 MemAddr  out  ADDR_W  synchronous ROM address; data returns 1 cycle later.
REQ-010 MemData  in  9  ROM read data.
REQ-011 DIN  out  9  processor data input.
REQ-012 Run  out  1  processor run strobe.
REQ-013 ProcResetn  out  1  processor reset; low clears the processor step counter.
REQ-014 Done  in  1  processor instruction-complete.
REQ-015 Busy  out  1  high in FETCH, ISSUE and EXEC.
REQ-016 Fault  out  1  high in FAULT.
REQ-017 PC  out  ADDR_W  current instruction address.
REQ-018 InstrCount  out  8  instructions completed since the last Start.

Function
REQ-019 States SHALL be IDLE, FETCH, ISSUE, EXEC, FAULT.
REQ-020 IDLE: Start=1 loads PC<=StartAddr, clears InstrCount and HaltPend, goes to FETCH; otherwise stays in IDLE.
REQ-021 FETCH: MemAddr=PC, ProcResetn=0, Run=0; next state is ISSUE.
REQ-022 ISSUE: if MemData[8]=1 (illegal opcode), go to FAULT with Run=0 and ProcResetn=0; otherwise DIN=MemData, Run=1, ProcResetn=1, capture MemData into IReg, MemAddr=PC+1 (prefetch), clear watchdog, go to EXEC.
REQ-023 EXEC: Run=1, ProcResetn=1; DIN=MemData (immediate) when IReg[8:6]=3'b001 (mvi), else DIN=IReg; watchdog increments each cycle.
REQ-024 EXEC with Done=1: InstrCount+=1 (wraps mod 256); PC+=2 for mvi, else PC+=1, modulo 2^ADDR_W.
REQ-025 EXEC with Done=1: go to IDLE if HaltPend, Halt or (new PC == EndAddr); otherwise go to FETCH.
REQ-026 EXEC: Done=0 when the watchdog reaches WDOG_LIMIT SHALL go to FAULT.
REQ-027 Halt=1 in any busy state SHALL set HaltPend; the current instruction always completes.
REQ-028 Start while Busy SHALL be ignored.
REQ-029 Done outside EXEC SHALL be ignored.
REQ-030 FAULT: Run=0, ProcResetn=0; Start=1 clears Fault and returns to IDLE without starting; PC and InstrCount hold.
REQ-031 In IDLE and FAULT, ProcResetn=0, Run=0, DIN=0.
REQ-032 PC wrap: mvi at address 2^ADDR_W-1 SHALL fetch its immediate from address 0; next PC is 1.
REQ-033 Latency: non-mvi instruction = FETCH+ISSUE+EXEC cycles; mvi = 3 cycles total.

Reset
REQ-034 Resetn low, asynchronously: state=IDLE, PC=0, InstrCount=0, HaltPend=0, IReg=0, watchdog=0.
REQ-035 Resetn low, asynchronously: outputs Busy=0, Fault=0, Run=0, ProcResetn=0, DIN=0, MemAddr=0.
REQ-036 Reset mid-instruction SHALL abandon the instruction with no count increment.

Structure
REQ-037 Shared package proc_seq_pkg SHALL hold the state encoding, OPC_MVI=3'b001 and the illegal-opcode rule.
REQ-038 Watchdog SHALL be sub-module proc_seq_wdog (clear, enable, limit-reached flag).
REQ-039 The next-state/output decode SHALL stay in proc_sequencer.

Verification
REQ-040 ROM[0]=mv R1,R0 (9'o010); StartAddr=0, EndAddr=1, Start pulse -> Done in first EXEC cycle, PC=1, InstrCount=1, returns to IDLE.
REQ-041 ROM[2]=mvi R0 (9'o100), ROM[3]=9'h0A5; StartAddr=2, EndAddr=4 -> DIN=9'h0A5 in EXEC, processor R0=9'h0A5, PC=4.
REQ-042 ROM[5]=add R1,R2 (9'o212) -> 3 EXEC cycles, Done in 3rd, PC=6; repeat with Done withheld -> FAULT after 3 EXEC cycles, Fault=1.
REQ-043 ROM[7]=9'o400 -> FAULT directly from ISSUE, Run never 1; Start then returns to IDLE with Fault=0.
REQ-044 mvi at address 31, ROM[0]=immediate 9'h1FF -> immediate taken from address 0, PC=1.
REQ-045 Halt pulsed in FETCH of a 4-instruction program -> that instruction completes, IDLE, InstrCount=1; Resetn low during EXEC -> all REQ-034/035 values within the same cycle.

Source files
------------

// File: rtl/proc_seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, opcode fields, decode helpers.
// Combinational helpers only; no latency and no flow control.
package proc_seq_pkg;

  localparam int INSTR_W = 9;
  localparam int COUNT_W = 8;
  localparam logic [2:0] OPC_MVI = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_EXEC,
    ST_FAULT
  } state_t;

  // Any instruction word with bit 8 set has no defined opcode.
  function automatic logic is_illegal(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1];
  endfunction

  function automatic logic is_mvi(input logic [INSTR_W-1:0] instr);
    return instr[8:6] == OPC_MVI;
  endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Control, ROM and processor-side signals of the sequencer.
// master = sequencer, slave = the surrounding system (ROM, processor, host control).
interface proc_sequencer_if
  import proc_seq_pkg::*;
#(
  parameter int ADDR_W = 5
);
  logic                start;
  logic                halt;
  logic [ADDR_W-1:0]   start_addr;
  logic [ADDR_W-1:0]   end_addr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [INSTR_W-1:0]  mem_data;
  logic [INSTR_W-1:0]  din;
  logic                run;
  logic                proc_resetn;
  logic                done;
  logic                busy;
  logic                fault;
  logic [ADDR_W-1:0]   pc;
  logic [COUNT_W-1:0]  instr_count;

  modport master (
    input  start, halt, start_addr, end_addr, mem_data, done,
    output mem_addr, din, run, proc_resetn, busy, fault, pc, instr_count
  );

  modport slave (
    output start, halt, start_addr, end_addr, mem_data, done,
    input  mem_addr, din, run, proc_resetn, busy, fault, pc, instr_count
  );

endinterface

// File: rtl/proc_seq_wdog.sv
// Execution watchdog: counts enabled cycles; o_limit flags the LIMIT-th cycle in progress.
// Flag is combinational from the count (same-cycle); counter saturates, no backpressure.
module proc_seq_wdog #(
  parameter int LIMIT = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_limit
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat   = (r_cnt >= CNT_W'(LIMIT));
  // Counts completed cycles, so the current cycle is number r_cnt+1.
  assign o_limit = (r_cnt >= CNT_W'(LIMIT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/proc_sequencer.sv
// Fetches instructions from a 1-cycle synchronous ROM and issues them to the processor.
// Latency FETCH+ISSUE+EXEC per instruction; EXEC stalls on Done, bounded by the watchdog.
module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int WDOG_LIMIT = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  proc_sequencer_if.master io_seq
);

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_W-1:0]    r_pc;
  logic [COUNT_W-1:0]   r_count;
  logic                 r_halt_pend;
  logic [INSTR_W-1:0]   r_ireg;

  logic [ADDR_W-1:0]    w_mem_addr;
  logic [INSTR_W-1:0]   w_din;
  logic                 w_run;
  logic                 w_proc_resetn;
  logic                 w_busy;
  logic                 w_wd_clr;
  logic                 w_wd_en;
  logic                 w_wd_limit;
  logic [ADDR_W-1:0]    w_pc_p1;
  logic [ADDR_W-1:0]    w_pc_next;

  assign w_busy    = (r_state == ST_FETCH) || (r_state == ST_ISSUE) || (r_state == ST_EXEC);
  assign w_pc_p1   = r_pc + ADDR_W'(1);
  // mvi carries its immediate in the following word, so it steps over it.
  assign w_pc_next = is_mvi(r_ireg) ? (r_pc + ADDR_W'(2)) : w_pc_p1;

  proc_seq_wdog #(
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_wd_clr),
    .i_en    (w_wd_en),
    .o_limit (w_wd_limit)
  );

  always_comb begin
    w_next        = r_state;
    w_mem_addr    = r_pc;
    w_din         = '0;
    w_run         = 1'b0;
    w_proc_resetn = 1'b0;
    w_wd_clr      = 1'b0;
    w_wd_en       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (io_seq.start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (is_illegal(io_seq.mem_data)) begin
          w_next = ST_FAULT;
        end else begin
          w_din         = io_seq.mem_data;
          w_run         = 1'b1;
          w_proc_resetn = 1'b1;
          w_mem_addr    = w_pc_p1;
          w_wd_clr      = 1'b1;
          w_next        = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_run         = 1'b1;
        w_proc_resetn = 1'b1;
        // Hold the prefetch address so the ROM keeps presenting the immediate.
        w_mem_addr    = w_pc_p1;
        w_wd_en       = 1'b1;
        w_din         = is_mvi(r_ireg) ? io_seq.mem_data : r_ireg;
        if (io_seq.done) begin
          if (r_halt_pend || io_seq.halt || (w_pc_next == io_seq.end_addr)) begin
            w_next = ST_IDLE;
          end else begin
            w_next = ST_FETCH;
          end
        end else if (w_wd_limit) begin
          w_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (io_seq.start) w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_count     <= '0;
      r_halt_pend <= 1'b0;
      r_ireg      <= '0;
    end else begin
      r_state <= w_next;
      if (w_busy && io_seq.halt) r_halt_pend <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (io_seq.start) begin
            r_pc        <= io_seq.start_addr;
            r_count     <= '0;
            r_halt_pend <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (!is_illegal(io_seq.mem_data)) r_ireg <= io_seq.mem_data;
        end
        ST_EXEC: begin
          if (io_seq.done) begin
            r_pc    <= w_pc_next;
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_seq.mem_addr    = w_mem_addr;
  assign io_seq.din         = w_din;
  assign io_seq.run         = w_run;
  assign io_seq.proc_resetn = w_proc_resetn;
  assign io_seq.busy        = w_busy;
  assign io_seq.fault       = (r_state == ST_FAULT);
  assign io_seq.pc          = r_pc;
  assign io_seq.instr_count = r_count;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: ROM and processor models, end-of-run results checked from a scoreboard.
module tb_proc_sequencer;

  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [7:0]    cnt;
    logic          fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  proc_sequencer_if #(.ADDR_W(AW)) sq ();

  proc_sequencer #(
    .ADDR_W     (AW),
    .WDOG_LIMIT (3)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_seq  (sq)
  );

  // Synchronous ROM
  logic [8:0] rom [0:31];
  always @(posedge clk) sq.mem_data <= rom[sq.mem_addr];

  // Processor model: step counter cleared by proc_resetn, Done after done_lat run cycles past issue
  int         done_lat = 0;
  int         step = 0;
  logic [8:0] p_ir = '0;
  logic [8:0] p_reg [0:7] = '{default: '0};

  always @(posedge clk) begin
    if (!sq.proc_resetn) begin
      step <= 0;
    end else if (sq.run) begin
      if (step == 0) p_ir <= sq.din;
      if (sq.done && p_ir[8:6] == 3'b001) p_reg[p_ir[5:3]] <= sq.din;
      step <= step + 1;
    end
  end

  assign sq.done = sq.run && sq.proc_resetn && (done_lat != 0) && (step == done_lat);

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb [$];
  exp_t m_e;
  logic prev_busy = 1'b0;
  logic saw_run;
  logic [8:0] done_din;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each busy->not-busy transition consumes one expected result.
  always @(negedge clk) begin
    if (prev_busy && !sq.busy) begin
      if (sb.size() == 0) begin
        chk("sb_depth", 32'(sb.size()), 32'd1);
      end else begin
        m_e = sb.pop_front();
        chk("end_pc", 32'(sq.pc), 32'(m_e.pc));
        chk("end_cnt", 32'(sq.instr_count), 32'(m_e.cnt));
        chk("end_fault", 32'(sq.fault), 32'(m_e.fault));
      end
    end
    prev_busy = sq.busy;
  end

  task automatic run_prog(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input int lat,
                          input logic [AW-1:0] e_pc, input logic [7:0] e_cnt, input logic e_flt,
                          input int e_cyc, input bit halt_first, input int poke);
    exp_t x;
    int   n;
    x.pc = e_pc;
    x.cnt = e_cnt;
    x.fault = e_flt;
    sb.push_back(x);
    sq.start_addr = sa;
    sq.end_addr = ea;
    done_lat = lat;
    saw_run = 1'b0;
    done_din = '0;
    sq.start = 1'b1;
    @(negedge clk);
    sq.start = 1'b0;
    n = 0;
    while (sq.busy && n < 60) begin
      if (sq.run) saw_run = 1'b1;
      if (sq.done) done_din = sq.din;
      sq.halt = halt_first && (n == 0);
      sq.start = (n == poke);
      n++;
      @(negedge clk);
    end
    sq.halt = 1'b0;
    sq.start = 1'b0;
    chk("busy_cycles", 32'(n), 32'(e_cyc));
  endtask

  task automatic pulse_start();
    sq.start = 1'b1;
    @(negedge clk);
    sq.start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(sq.busy), 32'd0);
    chk({tag, "_fault"}, 32'(sq.fault), 32'd0);
    chk({tag, "_run"}, 32'(sq.run), 32'd0);
    chk({tag, "_presetn"}, 32'(sq.proc_resetn), 32'd0);
    chk({tag, "_din"}, 32'(sq.din), 32'd0);
    chk({tag, "_maddr"}, 32'(sq.mem_addr), 32'd0);
    chk({tag, "_pc"}, 32'(sq.pc), 32'd0);
    chk({tag, "_cnt"}, 32'(sq.instr_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t x;
    sq.start = 1'b0;
    sq.halt = 1'b0;
    sq.start_addr = '0;
    sq.end_addr = '0;
    for (int i = 0; i < 32; i++) rom[i] = 9'o000;
    rom[0]  = 9'o010;
    rom[2]  = 9'o100;
    rom[3]  = 9'h0A5;
    rom[5]  = 9'o212;
    rom[7]  = 9'o400;
    for (int i = 8; i < 12; i++) rom[i] = 9'o010;
    rom[31] = 9'o100;

    #3;
    chk_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single mv, stops at EndAddr
    run_prog(5'd0, 5'd1, 1, 5'd1, 8'd1, 1'b0, 3, 1'b0, -1);

    // mvi takes its immediate from the next word
    run_prog(5'd2, 5'd4, 1, 5'd4, 8'd1, 1'b0, 3, 1'b0, -1);
    chk("mvi_din", 32'(done_din), 32'h0A5);
    chk("mvi_r0", 32'(p_reg[0]), 32'h0A5);

    // Slow add completes on 3rd EXEC cycle; withheld Done trips the watchdog
    run_prog(5'd5, 5'd6, 3, 5'd6, 8'd1, 1'b0, 5, 1'b0, -1);
    run_prog(5'd5, 5'd6, 0, 5'd5, 8'd0, 1'b1, 5, 1'b0, -1);
    chk("wdog_fault", 32'(sq.fault), 32'd1);
    pulse_start();
    chk("wdog_fault_clr", 32'(sq.fault), 32'd0);
    chk("wdog_clr_busy", 32'(sq.busy), 32'd0);
    chk("wdog_pc_hold", 32'(sq.pc), 32'd5);

    // Illegal opcode faults straight from ISSUE
    run_prog(5'd7, 5'd8, 1, 5'd7, 8'd0, 1'b1, 2, 1'b0, -1);
    chk("illegal_no_run", 32'(saw_run), 32'd0);
    pulse_start();
    chk("illegal_fault_clr", 32'(sq.fault), 32'd0);
    @(negedge clk);
    chk("illegal_no_autostart", 32'(sq.busy), 32'd0);

    // mvi at the top address wraps to 0 for its immediate
    rom[0] = 9'h1FF;
    run_prog(5'd31, 5'd1, 1, 5'd1, 8'd1, 1'b0, 3, 1'b0, -1);
    chk("wrap_din", 32'(done_din), 32'h1FF);
    chk("wrap_r0", 32'(p_reg[0]), 32'h1FF);

    // Four instructions; a Start while busy must not restart
    run_prog(5'd8, 5'd12, 1, 5'd12, 8'd4, 1'b0, 12, 1'b0, 3);

    // Halt in the first FETCH lets only that instruction finish
    run_prog(5'd8, 5'd12, 1, 5'd9, 8'd1, 1'b0, 3, 1'b1, -1);

    // Reset during EXEC abandons the instruction
    x.pc = '0;
    x.cnt = '0;
    x.fault = 1'b0;
    sb.push_back(x);
    sq.start_addr = 5'd5;
    sq.end_addr = 5'd6;
    done_lat = 3;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    chk("exec_run", 32'(sq.run), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
